// File: rtl/spi_sync.sv
// spi_sync -- multi-stage flip-flop synchronizer for one asynchronous input.
//   Shared by the SPI target and the SPI master.
// Parameters:
//   STAGES     number of flip-flop stages (2 or more)
//   RESET_VAL  value every stage takes while reset is high
// Ports:
//   clk    in   destination clock
//   reset  in   asynchronous, active-high reset
//   d      in   asynchronous input
//   q      out  synchronized output, STAGES clk cycles behind d
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= {STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave -- SPI mode-0 (CPOL=0, CPHA=0) target, MSB first.
//   spi_clk / spi_cs_n / spi_mosi are oversampled in the clk domain
//   (clk must be at least 8x spi_clk). One received byte is returned per
//   byte slot; spi_miso is driven from a single-entry transmit buffer.
// Parameters:
//   DATA_W       bits per SPI byte
//   SYNC_STAGES  synchronizer depth on each SPI input (2 or more)
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   spi_clk/cs_n/mosi  SPI pins from the master
//   spi_miso           target-out data
//   spi_miso_oe        1 = drive the spi_miso pad
//   tx_data/tx_valid   byte offered to the transmit buffer
//   tx_ready           buffer empty; tx_valid & tx_ready loads tx_data
//   rx_data/rx_valid   last complete received byte, 1-cycle update pulse
//   busy               synchronized chip select is active
//   tx_underrun        1-cycle pulse when a byte slot starts with no data
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Synchronized pins and edge detection
  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_prev_reg, cs_prev_reg;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(spi_clk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(spi_cs_n), .q(cs_n_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_s)
  );

  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s & sclk_prev_reg;
  assign cs_fall   = ~cs_n_s & cs_prev_reg;
  assign cs_rise   = cs_n_s & ~cs_prev_reg;

  // State
  state_t            state_reg, state_next;
  logic [DATA_W-1:0] buf_reg, buf_next;
  logic              buf_full_reg, buf_full_next;
  logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
  logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic              rx_valid_reg, rx_valid_next;
  logic              tx_underrun_reg, tx_underrun_next;
  logic              miso_reg, miso_next;
  logic              miso_oe_reg, miso_oe_next;
  logic              busy_reg, busy_next;
  logic              reload_reg, reload_next;
  logic              urun_pending_reg, urun_pending_next;
  logic              armed_reg, armed_next;

  logic              consume;
  logic [DATA_W-1:0] slot_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_prev_reg    <= 1'b0;
      cs_prev_reg      <= 1'b1;
      state_reg        <= ST_IDLE;
      buf_reg          <= '0;
      buf_full_reg     <= 1'b0;
      tx_shift_reg     <= '0;
      rx_shift_reg     <= '0;
      bit_cnt_reg      <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      tx_underrun_reg  <= 1'b0;
      miso_reg         <= 1'b0;
      miso_oe_reg      <= 1'b0;
      busy_reg         <= 1'b0;
      reload_reg       <= 1'b0;
      urun_pending_reg <= 1'b0;
      armed_reg        <= 1'b0;
    end else begin
      sclk_prev_reg    <= sclk_s;
      cs_prev_reg      <= cs_n_s;
      state_reg        <= state_next;
      buf_reg          <= buf_next;
      buf_full_reg     <= buf_full_next;
      tx_shift_reg     <= tx_shift_next;
      rx_shift_reg     <= rx_shift_next;
      bit_cnt_reg      <= bit_cnt_next;
      rx_data_reg      <= rx_data_next;
      rx_valid_reg     <= rx_valid_next;
      tx_underrun_reg  <= tx_underrun_next;
      miso_reg         <= miso_next;
      miso_oe_reg      <= miso_oe_next;
      busy_reg         <= busy_next;
      reload_reg       <= reload_next;
      urun_pending_reg <= urun_pending_next;
      armed_reg        <= armed_next;
    end
  end

  // Word that a starting byte slot takes from the buffer; zeros when empty.
  assign slot_word = buf_full_reg ? buf_reg : '0;

  always_comb begin
    state_next        = state_reg;
    buf_next          = buf_reg;
    buf_full_next     = buf_full_reg;
    tx_shift_next     = tx_shift_reg;
    rx_shift_next     = rx_shift_reg;
    bit_cnt_next      = bit_cnt_reg;
    rx_data_next      = rx_data_reg;
    rx_valid_next     = 1'b0;
    tx_underrun_next  = 1'b0;
    miso_next         = miso_reg;
    miso_oe_next      = miso_oe_reg;
    busy_next         = busy_reg;
    reload_next       = reload_reg;
    urun_pending_next = urun_pending_reg;
    armed_next        = armed_reg;
    consume           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        miso_oe_next = 1'b0;
        busy_next    = 1'b0;
        miso_next    = 1'b0;
        bit_cnt_next = '0;
        if (cs_fall) begin
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        consume           = 1'b1;
        tx_shift_next     = slot_word;
        tx_underrun_next  = ~buf_full_reg;
        miso_next         = slot_word[DATA_W-1];
        miso_oe_next      = 1'b1;
        busy_next         = 1'b1;
        bit_cnt_next      = '0;
        rx_shift_next     = '0;
        reload_next       = 1'b0;
        urun_pending_next = 1'b0;
        // A master that drops cs with spi_clk high is in error; ignore
        // edges until spi_clk has been seen low.
        armed_next        = ~sclk_s;
        state_next        = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (!sclk_s) begin
          armed_next = 1'b1;
        end
        if (armed_reg && sclk_rise) begin
          rx_shift_next = {rx_shift_reg[DATA_W-2:0], mosi_s};
          // A reloaded slot only counts as started once its first bit is
          // clocked, so the trailing fall of a frame's last byte never
          // reports an underrun for a slot that does not happen.
          if (urun_pending_reg) begin
            tx_underrun_next  = 1'b1;
            urun_pending_next = 1'b0;
          end
          if (bit_cnt_reg == LAST_BIT) begin
            rx_data_next  = {rx_shift_reg[DATA_W-2:0], mosi_s};
            rx_valid_next = 1'b1;
            bit_cnt_next  = '0;
            reload_next   = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        if (armed_reg && sclk_fall) begin
          if (reload_reg) begin
            consume           = 1'b1;
            tx_shift_next     = slot_word;
            miso_next         = slot_word[DATA_W-1];
            urun_pending_next = ~buf_full_reg;
            reload_next       = 1'b0;
          end else begin
            tx_shift_next = {tx_shift_reg[DATA_W-2:0], 1'b0};
            miso_next     = tx_shift_reg[DATA_W-2];
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Chip select release aborts the frame from any state.
    if (cs_rise) begin
      state_next        = ST_IDLE;
      bit_cnt_next      = '0;
      miso_oe_next      = 1'b0;
      busy_next         = 1'b0;
      miso_next         = 1'b0;
      reload_next       = 1'b0;
      urun_pending_next = 1'b0;
      armed_next        = 1'b0;
    end

    // Consume before load: a byte arriving in the same cycle as a slot
    // start misses that slot and waits for the next one.
    if (consume) begin
      buf_full_next = 1'b0;
    end
    if (tx_valid && !buf_full_reg) begin
      buf_next      = tx_data;
      buf_full_next = 1'b1;
    end
  end

  assign spi_miso    = miso_reg;
  assign spi_miso_oe = miso_oe_reg;
  assign tx_ready    = ~buf_full_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign busy        = busy_reg;
  assign tx_underrun = tx_underrun_reg;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave -- directed, table-driven bench for spi_slave (DATA_W=8,
//   SYNC_STAGES=2). A behavioural mode-0 master runs spi_clk at clk/8.
module tb_spi_slave;

  localparam int DATA_W = 8;
  localparam int SYNC   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              spi_clk = 1'b0;
  logic              spi_cs_n = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso, spi_miso_oe;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, busy, tx_underrun;

  spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Monitor: every rx_valid pulse and every underrun pulse.
  logic [7:0] rx_q[$];
  int         urun_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_underrun) urun_cnt++;
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passed++;
      $display("check %-14s got 0x%0h expected 0x%0h ok", name, actual, expected);
    end else begin
      $display("FAIL %-14s got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Master side of one frame. cut != 0 raises cs after that many bits.
  logic [7:0] m_tx[3];
  logic [7:0] m_rx[3];
  logic       oe_after_cs;

  task automatic spi_frame(input int nbytes, input int cut);
    int  nbits;
    bit  stop;
    nbits = 0;
    stop  = 1'b0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < nbytes; b++) begin
      m_rx[b] = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        if (cut != 0 && nbits == cut) stop = 1'b1;
        if (!stop) begin
          spi_mosi = m_tx[b][i];
          repeat (4) @(negedge clk);
          m_rx[b][i] = spi_miso;
          spi_clk = 1'b1;
          repeat (4) @(negedge clk);
          spi_clk = 1'b0;
          nbits++;
        end
      end
    end
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    #1 oe_after_cs = spi_miso_oe;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic       load;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_urun;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int rx_base, u_base, t;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 0};
    vecs[1] = '{1'b0, 8'h00, 8'hC3, 8'hC3, 8'h00, 1};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 0};
    vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00, 0};
    vecs[4] = '{1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81, 0};

    // Reset values
    #12;
    check("rst_tx_ready", tx_ready, 1);
    check("rst_miso_oe", spi_miso_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_miso", spi_miso, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single-byte frames from the table
    for (int v = 0; v < 5; v++) begin
      rx_base = rx_q.size();
      u_base  = urun_cnt;
      if (vecs[v].load) load_byte(vecs[v].tx);
      m_tx[0] = vecs[v].mosi;
      spi_frame(1, 0);
      check($sformatf("v%0d_rx_cnt", v), rx_q.size() - rx_base, 1);
      if (rx_q.size() > rx_base) check($sformatf("v%0d_rx", v), rx_q[rx_base], vecs[v].exp_rx);
      check($sformatf("v%0d_miso", v), m_rx[0], vecs[v].exp_miso);
      check($sformatf("v%0d_urun", v), urun_cnt - u_base, vecs[v].exp_urun);
    end

    // Three-byte frame, refilling the buffer whenever it empties
    rx_base = rx_q.size();
    u_base  = urun_cnt;
    load_byte(8'h11);
    m_tx[0] = 8'h01; m_tx[1] = 8'h02; m_tx[2] = 8'h03;
    fork
      spi_frame(3, 0);
      begin
        for (int k = 0; k < 2; k++) begin
          t = 0;
          while (!tx_ready && t < 2000) begin
            @(negedge clk);
            t++;
          end
          if (t >= 2000) check("refill_wait", 0, 1);
          load_byte(k == 0 ? 8'h22 : 8'h33);
        end
      end
    join
    check("b3_rx_cnt", rx_q.size() - rx_base, 3);
    if (rx_q.size() >= rx_base + 3) begin
      check("b3_rx0", rx_q[rx_base], 8'h01);
      check("b3_rx1", rx_q[rx_base+1], 8'h02);
      check("b3_rx2", rx_q[rx_base+2], 8'h03);
    end
    check("b3_miso0", m_rx[0], 8'h11);
    check("b3_miso1", m_rx[1], 8'h22);
    check("b3_miso2", m_rx[2], 8'h33);
    check("b3_urun", urun_cnt - u_base, 0);

    // Aborted frame after 5 bits, then a clean frame
    rx_base = rx_q.size();
    load_byte(8'h5A);
    m_tx[0] = 8'hE7;
    spi_frame(1, 5);
    check("cut_rx_cnt", rx_q.size() - rx_base, 0);
    check("cut_oe", oe_after_cs, 0);
    check("cut_busy", busy, 0);
    rx_base = rx_q.size();
    load_byte(8'h69);
    m_tx[0] = 8'h96;
    spi_frame(1, 0);
    check("after_cut_cnt", rx_q.size() - rx_base, 1);
    if (rx_q.size() > rx_base) check("after_cut_rx", rx_q[rx_base], 8'h96);
    check("after_cut_miso", m_rx[0], 8'h69);

    // Buffer is left alone by tx_valid while full
    u_base = urun_cnt;
    load_byte(8'h12);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hEE;
    repeat (6) @(negedge clk);
    tx_valid = 1'b0;
    check("full_ready", tx_ready, 0);
    m_tx[0] = 8'h5A;
    spi_frame(1, 0);
    check("full_miso", m_rx[0], 8'h12);
    check("full_urun", urun_cnt - u_base, 0);

    // Load landing in the same cycle as the slot start
    rx_base = rx_q.size();
    u_base  = urun_cnt;
    m_tx[0] = 8'h5A; m_tx[1] = 8'hC3;
    fork
      spi_frame(2, 0);
      begin
        @(negedge clk);
        repeat (3) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hB4;
        @(negedge clk);
        tx_valid = 1'b0;
        check("coin_urun_now", tx_underrun, 1);
        check("coin_ready", tx_ready, 0);
      end
    join
    check("coin_miso0", m_rx[0], 8'h00);
    check("coin_miso1", m_rx[1], 8'hB4);
    check("coin_urun", urun_cnt - u_base, 1);
    check("coin_rx_cnt", rx_q.size() - rx_base, 2);
    if (rx_q.size() >= rx_base + 2) check("coin_rx1", rx_q[rx_base+1], 8'hC3);

    // Reset in the middle of a byte, with a byte waiting in the buffer
    load_byte(8'h77);
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    load_byte(8'h44);
    for (int i = 0; i < 3; i++) begin
      spi_mosi = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_ready", tx_ready, 0);
    #2 reset = 1'b1;
    #1;
    check("mr_miso_oe", spi_miso_oe, 0);
    check("mr_busy", busy, 0);
    check("mr_ready", tx_ready, 1);
    check("mr_rx_data", rx_data, 0);
    check("mr_miso", spi_miso, 0);
    spi_cs_n = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    rx_base = rx_q.size();
    u_base  = urun_cnt;
    m_tx[0] = 8'h0F;
    spi_frame(1, 0);
    check("pr_miso", m_rx[0], 8'h00);
    check("pr_urun", urun_cnt - u_base, 1);
    if (rx_q.size() > rx_base) check("pr_rx", rx_q[rx_base], 8'h0F);
    else check("pr_rx_cnt", rx_q.size() - rx_base, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
